// File: rtl/axi_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : axi_frame_packer
// Description : Splits AXI4 INCR write/read-address bursts into one array frame
//               per beat {rw, sof, eof, raddr, caddr, data} on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_frame_packer #(
    parameter int DATA_WIDTH  = 64,
    parameter int RADDR_WIDTH = 14,
    parameter int CADDR_WIDTH = 6,
    parameter int ADDR_WIDTH  = 32,
    parameter int FRAME_WIDTH = DATA_WIDTH + RADDR_WIDTH + CADDR_WIDTH + 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mc_en,
    input  logic [ADDR_WIDTH-1:0]  awaddr,
    input  logic [7:0]             awlen,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [ADDR_WIDTH-1:0]  araddr,
    input  logic [7:0]             arlen,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [FRAME_WIDTH-1:0] frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ready
);

    localparam int                     c_OFFSET    = $clog2(DATA_WIDTH / 8);
    localparam int                     c_ROW_LSB   = c_OFFSET + CADDR_WIDTH;
    localparam logic [CADDR_WIDTH-1:0] c_CADDR_ONE = CADDR_WIDTH'(1);
    localparam logic [RADDR_WIDTH-1:0] c_RADDR_ONE = RADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_BURST = 2'd1,
        S_WR_RESP  = 2'd2,
        S_RD_BURST = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CADDR_WIDTH-1:0]   r_caddr;
    logic [RADDR_WIDTH-1:0]   r_raddr;
    logic [7:0]               r_len;
    logic [7:0]               r_cnt;
    logic                     r_sof;
    logic                     r_err;
    logic                     r_rr_wr;
    logic                     r_frame_valid;
    logic [FRAME_WIDTH-1:0]   r_frame_data;
    logic                     r_bvalid;
    logic                     w_load_ok;
    logic                     w_beat;
    logic                     w_final;
    logic                     w_wrap;
    logic                     w_is_wr;
    logic                     w_unused;

    assign w_load_ok = !r_frame_valid || frame_ready;
    assign w_final   = (r_cnt == r_len);
    assign w_wrap    = &r_caddr;
    assign w_is_wr   = (r_state == S_WR_BURST);
    // Only the row/column slice of the byte address is meaningful to the array.
    assign w_unused  = ^{awaddr, araddr};

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign bvalid      = r_bvalid;
    assign bresp       = {r_bvalid & r_err, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        awready      = 1'b0;
        arready      = 1'b0;
        wready       = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mc_en) begin
                    // r_rr_wr breaks the tie when both address channels are valid.
                    if (awvalid && (r_rr_wr || !arvalid)) begin
                        awready      = 1'b1;
                        w_next_state = S_WR_BURST;
                    end else if (arvalid) begin
                        arready      = 1'b1;
                        w_next_state = S_RD_BURST;
                    end
                end
            end
            S_WR_BURST: begin
                wready = w_load_ok;
                if (wvalid && w_load_ok) begin
                    w_beat = 1'b1;
                    if (w_final) begin
                        w_next_state = S_WR_RESP;
                    end
                end
            end
            S_RD_BURST: begin
                if (w_load_ok) begin
                    w_beat = 1'b1;
                    if (w_final) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_WR_RESP: begin
                if (r_bvalid && bready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_caddr       <= '0;
            r_raddr       <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_sof         <= 1'b0;
            r_err         <= 1'b0;
            r_rr_wr       <= 1'b1;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_bvalid      <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                r_caddr <= awaddr[c_OFFSET +: CADDR_WIDTH];
                r_raddr <= awaddr[c_ROW_LSB +: RADDR_WIDTH];
                r_len   <= awlen;
                r_cnt   <= '0;
                r_sof   <= 1'b1;
                r_err   <= 1'b0;
                r_rr_wr <= 1'b0;
            end else if (arvalid && arready) begin
                r_caddr <= araddr[c_OFFSET +: CADDR_WIDTH];
                r_raddr <= araddr[c_ROW_LSB +: RADDR_WIDTH];
                r_len   <= arlen;
                r_cnt   <= '0;
                r_sof   <= 1'b1;
                r_rr_wr <= 1'b1;
            end else if (w_beat) begin
                r_cnt   <= r_cnt + 8'd1;
                r_caddr <= r_caddr + c_CADDR_ONE;
                r_sof   <= w_wrap;
                if (w_wrap) begin
                    r_raddr <= r_raddr + c_RADDR_ONE;
                end
                // wlast must be high on exactly the final beat.
                if (w_is_wr && (w_final != wlast)) begin
                    r_err <= 1'b1;
                end
            end

            if (w_load_ok) begin
                r_frame_valid <= w_beat;
                if (w_beat) begin
                    r_frame_data <= {w_is_wr, r_sof, w_final | w_wrap, r_raddr, r_caddr,
                                     w_is_wr ? wdata : {DATA_WIDTH{1'b0}}};
                end
            end

            if (r_bvalid) begin
                if (bready) begin
                    r_bvalid <= 1'b0;
                end
            end else if ((r_state == S_WR_RESP) && w_load_ok) begin
                r_bvalid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
